axi_ram_loader: RTL

AXI4 write-side sequencer that fills an axi_ram region from a valid/ready word stream (boot image, UART/DMA ingest). It splits the transfer into INCR bursts, keeps one burst outstanding and reports completion and errors.

---
 rtl/axi_ram_loader_pkg.sv | 32 +++
 rtl/axi_ram_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axi_ram_loader_pkg.sv
// Shared types and helpers for the AXI RAM loader.
// State encoding, AXI constants and the burst-length rule.
package axi_ram_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int unsigned BOUNDARY_BYTES = 4096;

   // A burst never crosses a 4 KB page.
   function automatic int unsigned beats(
      input int unsigned addr,
      input int unsigned remaining,
      input int unsigned max_burst,
      input int unsigned bytes
   );
      int unsigned room;
      int unsigned n;
      room = (BOUNDARY_BYTES - (addr % BOUNDARY_BYTES)) / bytes;
      n = max_burst;
      if (remaining < n) n = remaining;
      if (room < n) n = room;
      return n;
   endfunction

endpackage

// File: rtl/axi_ram_loader.sv
// Stream-to-AXI4 write loader, one INCR burst outstanding.
// Optional AXI_RAM_LOADER_CSUM_EN adds a running word sum on csum_o.
module axi_ram_loader
   import axi_ram_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] num_words_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
   output logic [LEN_WIDTH-1:0]  axi_awlen_o,
   output logic                  axi_awvalid_o,
   input  logic                  axi_awready_i,
   output logic [DATA_WIDTH-1:0] axi_wdata_o,
   output logic                  axi_wlast_o,
   output logic                  axi_wvalid_o,
   input  logic                  axi_wready_i,
   input  logic [1:0]            axi_bresp_i,
   input  logic                  axi_bvalid_i,
   output logic                  axi_bready_o
`ifdef AXI_RAM_LOADER_CSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] csum_o
`endif
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] rem_q, rem_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] base_al;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic                  in_data;
   logic                  fire;

   assign base_al  = base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
   assign nxt_addr = addr_q
      + ADDR_WIDTH'((32'(len_q) + 32'd1) * BYTES);
   assign in_data  = (state_q == ST_DATA);
   assign fire     = in_data && s_valid_i && axi_wready_i;

`ifdef AXI_RAM_LOADER_CSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      len_d   = len_q;
      beat_d  = beat_q;
      done_d  = 1'b0;
      err_d   = err_q;
`ifdef AXI_RAM_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               err_d = 1'b0;
`ifdef AXI_RAM_LOADER_CSUM_EN
               csum_d = '0;
`endif
               if (num_words_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ADDR;
                  addr_d  = base_al;
                  rem_d   = num_words_i;
                  len_d   = LEN_WIDTH'(beats(32'(base_al),
                     32'(num_words_i), MAX_BURST, BYTES) - 1);
               end
            end
         end
         ST_ADDR: begin
            if (axi_awready_i) begin
               state_d = ST_DATA;
               beat_d  = '0;
            end
         end
         ST_DATA: begin
            if (fire) begin
               beat_d = beat_q + 1'b1;
               rem_d  = rem_q - 1'b1;
`ifdef AXI_RAM_LOADER_CSUM_EN
               csum_d = csum_q + s_data_i;
`endif
               if (beat_q == len_q) state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (axi_bvalid_i) begin
               if (axi_bresp_i != AXI_RESP_OKAY) err_d = 1'b1;
               addr_d = nxt_addr;
               if (rem_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ADDR;
                  len_d   = LEN_WIDTH'(beats(32'(nxt_addr),
                     32'(rem_q), MAX_BURST, BYTES) - 1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef AXI_RAM_LOADER_CSUM_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) csum_q <= '0;
      else          csum_q <= csum_d;
   end

   assign csum_o = csum_q;
`endif

   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign s_ready_o     = in_data && axi_wready_i;
   assign axi_awaddr_o  = addr_q;
   assign axi_awlen_o   = len_q;
   assign axi_awvalid_o = (state_q == ST_ADDR);
   assign axi_wdata_o   = in_data ? s_data_i : '0;
   assign axi_wlast_o   = in_data && (beat_q == len_q);
   assign axi_wvalid_o  = in_data && s_valid_i;
   assign axi_bready_o  = (state_q == ST_RESP);

endmodule
